seven_segment_capture: RTL and testbench
========================================

Name: seven_segment_capture

Overview:
- Reverse path of the team's BCD-to-seven-segment decoder: watches a multiplexed, active-high seven-segment display bus (segments a-g plus one-hot digit enables) and recovers the 4-bit code shown on each digit.
- Each pattern must be stable for a set number of cycles before it is accepted. Accepted patterns are decoded back to 0-9 or blank and stored per digit, with a pulse on each capture and at the end of each full frame.
- Used as a loopback checker for display drivers and for reading external displays.

Parameters:
- NUM_DIGITS, 4, number of digit enables (at least 2).
- STABLE_CYCLES, 8, consecutive identical samples required before capture (at least 2).
- IDX_W, $clog2(NUM_DIGITS), width of the digit index (derived, not overridden).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- seg_a..seg_g  input  1 each  segment lines, 1 = lit, same clock domain.
- an  input  NUM_DIGITS  digit enables, active-high, one-hot when valid.
- err_clr  input  1  clears err_flag.
- digits  output  4*NUM_DIGITS  stored codes; digit i occupies [4i+3:4i].
- dig_valid  output  1  one-cycle pulse on each accepted capture.
- dig_idx  output  IDX_W  digit index of the current capture.
- dig_code  output  4  code of the current capture.
- pat_err  output  1  one-cycle pulse when a stable pattern is not one of the 11 legal patterns.
- err_flag  output  1  sticky error flag.
- frame_valid  output  1  one-cycle pulse when every digit has been captured since the last pulse.

Behaviour:
- Reset (rst_n low at a clock edge):
  - digits = all 4'hF (blank); dig_valid, pat_err, frame_valid, err_flag = 0; dig_idx = 0; dig_code = 4'hF.
  - FSM to IDLE; stability counter and seen-mask cleared.
  - Reset mid-count abandons the pending capture.
- Input stage: {an, seg_g..seg_a} is registered once to form the sample. All comparisons use the registered sample.
- Legal patterns, listed as lit segments:
  - 0 = ABCDEF; 1 = BC; 2 = ABDEG; 3 = ABCDG; 4 = BCFG.
  - 5 = ACDFG; 6 = ACDEFG; 7 = ABC; 8 = ABCDEFG; 9 = ABCFG (no D).
  - All segments off = blank, code 4'hF, legal.
- FSM:
  - IDLE: sample an not one-hot (zero or multiple bits set); the counter is held at 0. Goes to COUNT when an is one-hot.
  - COUNT: counter increments while the sample equals the previous sample. Any change restarts at count 1 (or goes to IDLE if an becomes invalid). When the count reaches STABLE_CYCLES, the capture action is taken and the FSM goes to HOLD.
  - HOLD: the pattern has already been captured, so no repeat capture occurs. Any sample change goes to COUNT (count 1) or IDLE.
- Capture action for a legal pattern:
  - Write the code into digits[idx]; drive dig_code/dig_idx; pulse dig_valid.
  - Set the seen bit for idx.
  - If the seen-mask becomes all ones, pulse frame_valid in the same cycle and clear the mask.
- Capture action for an illegal pattern:
  - Pulse pat_err and set err_flag.
  - digits and seen-mask are unchanged; dig_valid stays 0.
- Latency: if inputs are constant from clock edge k, dig_valid (or pat_err) is high during the cycle following edge k+STABLE_CYCLES.
- Rewriting a digit with the same code still pulses dig_valid.
- err_flag: set on a pat_err capture, cleared by err_clr. If both occur in the same cycle, set wins.
- A glitch shorter than STABLE_CYCLES never causes a capture. After the glitch, the original pattern must be re-qualified for the full STABLE_CYCLES.
- Counter saturates at STABLE_CYCLES; no wrap.

Decomposition:
- Package seg7_pkg:
  - pattern constants SEG_0..SEG_9 and SEG_BLANK, 7-bit, order {g,f,e,d,c,b,a};
  - CODE_BLANK = 4'hF;
  - FSM state enum {IDLE, COUNT, HOLD}.
- Sub-module seg7_pattern_decode: combinational; 7-bit pattern in; 4-bit code and legal flag out. Shared with future display checkers.
- Top level holds the input register, FSM/counter, one-hot check and index encode, digit storage, and seen-mask.

Test Plan:
1. After reset, an=4'b0001 with pattern ABCDEF held for 8 cycles -> one dig_valid pulse, dig_idx=0, dig_code=0, digits=16'hFFF0. Holding 20 more cycles gives no second pulse.
2. Scan digits 0..3 with patterns 3, 9 (ABCFG), 7, blank, 8 cycles each -> four dig_valid pulses; frame_valid pulses coincident with the last one; digits=16'hF793.
3. On digit 1, pattern BC held 5 cycles, then a 1-cycle change to ABC, then BC again -> no capture until BC has been held 8 consecutive cycles after the glitch; then dig_code=1.
4. Illegal pattern ABG held 8 cycles on digit 2 -> pat_err pulse, err_flag=1, digits unchanged, no dig_valid. err_clr asserted in the same cycle as a second error -> err_flag stays 1.
5. an=4'b0011 or 4'b0000 for 30 cycles with a legal pattern -> no captures.
6. rst_n low at count 6 of a pending capture, then released with inputs unchanged -> digits all F; the capture occurs a full 8 cycles after the first post-reset sample.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: lit-segment patterns ordered {g,f,e,d,c,b,a},
// the blank code and the capture FSM state type.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'b0111111;
  localparam logic [6:0] SEG_1     = 7'b0000110;
  localparam logic [6:0] SEG_2     = 7'b1011011;
  localparam logic [6:0] SEG_3     = 7'b1001111;
  localparam logic [6:0] SEG_4     = 7'b1100110;
  localparam logic [6:0] SEG_5     = 7'b1101101;
  localparam logic [6:0] SEG_6     = 7'b1111101;
  localparam logic [6:0] SEG_7     = 7'b0000111;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1100111;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  localparam logic [3:0] CODE_BLANK = 4'hF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    HOLD  = 2'd2
  } cap_state_t;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Maps a lit-segment pattern back to its BCD code; anything outside the
// eleven known shapes is flagged as not legal.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] code,
  output logic       legal
);

  always_comb begin
    code  = CODE_BLANK;
    legal = 1'b1;
    case (pattern)
      SEG_0:     code = 4'd0;
      SEG_1:     code = 4'd1;
      SEG_2:     code = 4'd2;
      SEG_3:     code = 4'd3;
      SEG_4:     code = 4'd4;
      SEG_5:     code = 4'd5;
      SEG_6:     code = 4'd6;
      SEG_7:     code = 4'd7;
      SEG_8:     code = 4'd8;
      SEG_9:     code = 4'd9;
      SEG_BLANK: code = CODE_BLANK;
      default:   legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/seven_segment_capture.sv
// Recovers per-digit codes from a multiplexed seven-segment bus once each
// pattern has been stable long enough.
//
// state | meaning
// IDLE  | digit enables not one-hot, counter held at 0
// COUNT | qualifying a one-hot sample, counting identical samples
// HOLD  | current sample already captured, waiting for a change
module seven_segment_capture
  import seg7_pkg::*;
#(
  parameter  int NUM_DIGITS    = 4,
  parameter  int STABLE_CYCLES = 8,
  localparam int IDX_W         = $clog2(NUM_DIGITS)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    seg_a,
  input  logic                    seg_b,
  input  logic                    seg_c,
  input  logic                    seg_d,
  input  logic                    seg_e,
  input  logic                    seg_f,
  input  logic                    seg_g,
  input  logic [NUM_DIGITS-1:0]   an,
  input  logic                    err_clr,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic                    dig_valid,
  output logic [IDX_W-1:0]        dig_idx,
  output logic [3:0]              dig_code,
  output logic                    pat_err,
  output logic                    err_flag,
  output logic                    frame_valid
);

  localparam int SW    = NUM_DIGITS + 7;
  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0]      CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [NUM_DIGITS-1:0] AN_ONE   = NUM_DIGITS'(1);

  cap_state_t             state;
  logic [SW-1:0]          sample_q;
  logic [SW-1:0]          prev_q;
  logic [CNT_W-1:0]       cnt;
  logic [NUM_DIGITS-1:0]  seen;

  logic [NUM_DIGITS-1:0]  an_s;
  logic                   an_onehot;
  logic                   changed;
  logic [IDX_W-1:0]       idx;
  logic [3:0]             code;
  logic                   legal;

  assign an_s      = sample_q[SW-1:7];
  assign an_onehot = (an_s != '0) && ((an_s & (an_s - AN_ONE)) == '0);
  assign changed   = (sample_q != prev_q);

  always_comb begin
    idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (an_s[i]) idx = IDX_W'(i);
  end

  seg7_pattern_decode u_decode (
    .pattern (sample_q[6:0]),
    .code    (code),
    .legal   (legal)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      sample_q    <= '0;
      prev_q      <= '0;
      cnt         <= '0;
      seen        <= '0;
      digits      <= '1;
      dig_valid   <= 1'b0;
      dig_idx     <= '0;
      dig_code    <= CODE_BLANK;
      pat_err     <= 1'b0;
      err_flag    <= 1'b0;
      frame_valid <= 1'b0;
    end else begin
      sample_q    <= {an, seg_g, seg_f, seg_e, seg_d, seg_c, seg_b, seg_a};
      prev_q      <= sample_q;
      dig_valid   <= 1'b0;
      pat_err     <= 1'b0;
      frame_valid <= 1'b0;
      if (err_clr) err_flag <= 1'b0;

      case (state)
        IDLE: begin
          if (an_onehot) begin
            state <= COUNT;
            cnt   <= CNT_ONE;
          end else begin
            cnt <= '0;
          end
        end
        COUNT: begin
          if (!an_onehot) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (changed) begin
            cnt <= CNT_ONE;
          end else if (cnt == CNT_LAST) begin
            cnt   <= cnt + CNT_ONE;
            state <= HOLD;
            if (legal) begin
              digits[4*idx +: 4] <= code;
              dig_code           <= code;
              dig_idx            <= idx;
              dig_valid          <= 1'b1;
              // Completing the mask reports the frame and starts the next one.
              if ((seen | an_s) == '1) begin
                frame_valid <= 1'b1;
                seen        <= '0;
              end else begin
                seen <= seen | an_s;
              end
            end else begin
              pat_err  <= 1'b1;
              err_flag <= 1'b1;
            end
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        HOLD: begin
          if (!an_onehot) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (changed) begin
            state <= COUNT;
            cnt   <= CNT_ONE;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seven_segment_capture.sv
// Directed bench for seven_segment_capture: inputs driven and outputs checked
// on the falling clock edge.
module tb_seven_segment_capture;

  localparam logic [6:0] P_0     = 7'b0111111;
  localparam logic [6:0] P_1     = 7'b0000110;
  localparam logic [6:0] P_3     = 7'b1001111;
  localparam logic [6:0] P_5     = 7'b1101101;
  localparam logic [6:0] P_7     = 7'b0000111;
  localparam logic [6:0] P_8     = 7'b1111111;
  localparam logic [6:0] P_9     = 7'b1100111;
  localparam logic [6:0] P_BLANK = 7'b0000000;
  localparam logic [6:0] P_ABG   = 7'b1000011;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g;
  logic [3:0]  an;
  logic        err_clr;
  logic [15:0] digits;
  logic        dig_valid;
  logic [1:0]  dig_idx;
  logic [3:0]  dig_code;
  logic        pat_err;
  logic        err_flag;
  logic        frame_valid;

  int vectors     = 0;
  int miscompares = 0;
  int v_cnt, e_cnt, f_cnt, f_with_v;

  always #5 clk = ~clk;

  seven_segment_capture dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .seg_a       (seg_a),
    .seg_b       (seg_b),
    .seg_c       (seg_c),
    .seg_d       (seg_d),
    .seg_e       (seg_e),
    .seg_f       (seg_f),
    .seg_g       (seg_g),
    .an          (an),
    .err_clr     (err_clr),
    .digits      (digits),
    .dig_valid   (dig_valid),
    .dig_idx     (dig_idx),
    .dig_code    (dig_code),
    .pat_err     (pat_err),
    .err_flag    (err_flag),
    .frame_valid (frame_valid)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic [3:0] a, input logic [6:0] p);
    an = a;
    {seg_g, seg_f, seg_e, seg_d, seg_c, seg_b, seg_a} = p;
  endtask

  task automatic clear_counts();
    v_cnt = 0; e_cnt = 0; f_cnt = 0; f_with_v = 0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (dig_valid) v_cnt++;
      if (pat_err) e_cnt++;
      if (frame_valid) begin
        f_cnt++;
        if (dig_valid) f_with_v++;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; err_clr = 1'b0;
    set_in(4'b0000, P_BLANK);
    repeat (3) @(negedge clk);
    check("rst_digits", 32'(digits), 32'hFFFF);
    check("rst_dig_valid", 32'(dig_valid), 0);
    check("rst_dig_idx", 32'(dig_idx), 0);
    check("rst_dig_code", 32'(dig_code), 32'hF);
    check("rst_pat_err", 32'(pat_err), 0);
    check("rst_err_flag", 32'(err_flag), 0);
    check("rst_frame_valid", 32'(frame_valid), 0);
    rst_n = 1'b1;

    // 1: first capture on digit 0, latency and no repeat while held
    set_in(4'b0001, P_0);
    clear_counts(); run(8);
    check("t1_early", 32'(v_cnt), 0);
    run(1);
    check("t1_valid", 32'(dig_valid), 1);
    check("t1_idx", 32'(dig_idx), 0);
    check("t1_code", 32'(dig_code), 0);
    check("t1_digits", 32'(digits), 32'hFFF0);
    clear_counts(); run(20);
    check("t1_no_repeat", 32'(v_cnt), 0);

    // 2: full scan, frame with the last capture
    clear_counts();
    set_in(4'b0001, P_3);     run(12);
    set_in(4'b0010, P_9);     run(12);
    set_in(4'b0100, P_7);     run(12);
    set_in(4'b1000, P_BLANK); run(12);
    check("t2_captures", 32'(v_cnt), 4);
    check("t2_frames", 32'(f_cnt), 1);
    check("t2_frame_coincident", 32'(f_with_v), 1);
    check("t2_digits", 32'(digits), 32'hF793);
    check("t2_last_code", 32'(dig_code), 32'hF);
    check("t2_last_idx", 32'(dig_idx), 3);

    // 3: one-cycle glitch forces full re-qualification
    clear_counts();
    set_in(4'b0010, P_1); run(5);
    set_in(4'b0010, P_7); run(1);
    set_in(4'b0010, P_1); run(8);
    check("t3_no_early", 32'(v_cnt), 0);
    run(1);
    check("t3_valid", 32'(dig_valid), 1);
    check("t3_code", 32'(dig_code), 1);
    check("t3_idx", 32'(dig_idx), 1);
    check("t3_digits", 32'(digits), 32'hF713);

    // 4: illegal pattern, clear, then clear colliding with a new error
    clear_counts();
    set_in(4'b0100, P_ABG); run(8);
    check("t4_no_early_err", 32'(e_cnt), 0);
    run(1);
    check("t4_pat_err", 32'(pat_err), 1);
    check("t4_no_valid", 32'(dig_valid), 0);
    check("t4_err_flag", 32'(err_flag), 1);
    run(4);
    check("t4_single_err", 32'(e_cnt), 1);
    err_clr = 1'b1; run(1); err_clr = 1'b0;
    check("t4_cleared", 32'(err_flag), 0);
    set_in(4'b0001, P_ABG); run(8);
    err_clr = 1'b1; run(1); err_clr = 1'b0;
    check("t4_pat_err2", 32'(pat_err), 1);
    run(1);
    check("t4_set_wins", 32'(err_flag), 1);
    check("t4_digits", 32'(digits), 32'hF713);
    check("t4_no_captures", 32'(v_cnt), 0);

    // 5: invalid digit enables never capture
    clear_counts();
    set_in(4'b0011, P_8); run(30);
    set_in(4'b0000, P_8); run(30);
    check("t5_no_valid", 32'(v_cnt), 0);
    check("t5_no_err", 32'(e_cnt), 0);
    check("t5_digits", 32'(digits), 32'hF713);

    // 6: reset at count 6 abandons the capture; full requalify afterwards
    clear_counts();
    set_in(4'b0001, P_5); run(7);
    rst_n = 1'b0; run(1); rst_n = 1'b1;
    check("t6_rst_digits", 32'(digits), 32'hFFFF);
    check("t6_rst_err_flag", 32'(err_flag), 0);
    check("t6_no_capture_pre", 32'(v_cnt), 0);
    run(8);
    check("t6_no_early", 32'(v_cnt), 0);
    run(1);
    check("t6_valid", 32'(dig_valid), 1);
    check("t6_code", 32'(dig_code), 5);
    check("t6_digits", 32'(digits), 32'hFFF5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
